fir_transposed_param: RTL



---
 rtl/fir_transposed_param_if.sv | 29 ++
 rtl/fir_transposed_param.sv | 113 +++++++++++
 2 files changed

// File: rtl/fir_transposed_param_if.sv
// Stream handshake, coefficient-load port and clear for fir_transposed_param.
// Y_W must match the filter's output width: ACC_W by default, OUT_W with FIR_ROUND_SAT_EN.
interface fir_transposed_param_if #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 6,
    parameter int Y_W     = 38
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [Y_W-1:0]     out_data;
    logic                      coeff_we;
    logic        [ADDR_W-1:0]  coeff_addr;
    logic signed [COEFF_W-1:0] coeff_wdata;
    logic                      clear;

    modport slave (
        input  in_valid, in_data, out_ready, coeff_we, coeff_addr, coeff_wdata, clear,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready, coeff_we, coeff_addr, coeff_wdata, clear,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with runtime-loadable coefficients, valid/ready stream and sync clear.
// Optional macro FIR_ROUND_SAT_EN: round half-up and saturate the result to OUT_W bits.
module fir_transposed_param #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16,
    parameter int NUMTAPS = 64,
    parameter int ACC_W   = DATA_W + COEFF_W + $clog2(NUMTAPS),
    parameter int OUT_W   = DATA_W + COEFF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fir_transposed_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUMTAPS);
    localparam int PROD_W = DATA_W + COEFF_W;
`ifdef FIR_ROUND_SAT_EN
    localparam int Y_W = OUT_W;
`else
    localparam int Y_W = ACC_W;
`endif

    if (NUMTAPS < 2 || NUMTAPS > 256 || ACC_W < PROD_W || OUT_W < 2 || OUT_W > ACC_W) begin : g_param_check
        $error("fir_transposed_param: illegal parameter combination");
    end

    logic signed [COEFF_W-1:0] r_coeff [NUMTAPS];
    logic signed [ACC_W-1:0]   r_z     [1:NUMTAPS-1];
    logic                      r_out_valid;
    logic signed [Y_W-1:0]     r_out_data;

    logic signed [ACC_W-1:0]   w_tap   [NUMTAPS];
    logic signed [Y_W-1:0]     w_y;
    logic                      w_in_ready;
    logic                      w_accept;

    assign w_in_ready = !bus.clear && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Tap k: full-precision product plus the partial sum arriving from tap k+1.
    for (genvar k = 0; k < NUMTAPS; k++) begin : g_tap
        logic signed [PROD_W-1:0] w_prod;
        assign w_prod = PROD_W'(r_coeff[k]) * PROD_W'(bus.in_data);
        if (k == NUMTAPS - 1) begin : g_last
            assign w_tap[k] = ACC_W'(w_prod);
        end else begin : g_mid
            assign w_tap[k] = ACC_W'(w_prod) + r_z[k+1];
        end
    end

`ifdef FIR_ROUND_SAT_EN
    localparam int SH = ACC_W - OUT_W;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_rnd;

    assign w_ext = {w_tap[0][ACC_W-1], w_tap[0]};

    // Round half-up at bit SH-1 and keep the scale; saturation then clips to OUT_W.
    if (SH > 0) begin : g_round
        localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SH - 1);
        localparam logic [ACC_W:0] MASK = ~(((ACC_W+1)'(1) << SH) - (ACC_W+1)'(1));
        assign w_rnd = (w_ext + HALF) & MASK;
    end else begin : g_no_round
        assign w_rnd = w_ext;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_y and no latch is inferred.
        w_y = w_rnd[OUT_W-1:0];
        if (w_rnd > SAT_MAX) begin
            w_y = SAT_MAX[OUT_W-1:0];
        end else if (w_rnd < SAT_MIN) begin
            w_y = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    assign w_y = w_tap[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: coefficients are reset too: they must read zero after reset, so this stays a flop array, not RAM.
            for (int k = 0; k < NUMTAPS; k++) r_coeff[k] <= '0;
            for (int k = 1; k < NUMTAPS; k++) r_z[k] <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // Out-of-range addresses match no tap and are dropped.
            for (int k = 0; k < NUMTAPS; k++) begin
                if (bus.coeff_we && bus.coeff_addr == ADDR_W'(k)) r_coeff[k] <= bus.coeff_wdata;
            end

            if (bus.clear) begin
                for (int k = 1; k < NUMTAPS; k++) r_z[k] <= '0;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else if (w_accept) begin
                // NOTE: non-blocking, so each tap sees its neighbour's pre-edge partial sum.
                for (int k = 1; k < NUMTAPS; k++) r_z[k] <= w_tap[k];
                r_out_data  <= w_y;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
